// File: rtl/keypad_if.sv
// keypad_if: key matrix pins plus decoded key outputs; key_release_o exists only with KEYPAD_RELEASE_EN
interface keypad_if;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_code_o;
  logic       key_valid_o;
  logic       key_down_o;
`ifdef KEYPAD_RELEASE_EN
  logic       key_release_o;
  modport master (input row_i, output col_o, key_code_o, key_valid_o, key_down_o, key_release_o);
  modport slave  (output row_i, input col_o, key_code_o, key_valid_o, key_down_o, key_release_o);
`else
  modport master (input row_i, output col_o, key_code_o, key_valid_o, key_down_o);
  modport slave  (output row_i, input col_o, key_code_o, key_valid_o, key_down_o);
`endif
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix scanner with debounce; KEYPAD_RELEASE_EN adds a key_release pulse
module keypad_scan #(
  parameter logic [15:0] SCAN_DIV       = 16'd50000,
  parameter logic [7:0]  DEBOUNCE_TICKS = 8'd4
) (
  input logic      clk,
  input logic      reset,
  keypad_if.master kp
);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  state_t      state_q;
  logic [3:0]  sync_q, row_s_q, cand_q, key_code_q;
  logic [15:0] pre_q;
  logic [1:0]  col_idx_q;
  logic [7:0]  deb_cnt_q;
  logic        key_valid_q, key_down_q;
  logic        tick, hit, cand_open;
  logic [1:0]  hit_row;
  logic [7:0]  deb_d;
`ifdef KEYPAD_RELEASE_EN
  logic        key_release_q;
  assign kp.key_release_o = key_release_q;
`endif
  always_comb begin
    tick      = pre_q == SCAN_DIV - 16'd1;
    hit       = ~&row_s_q;
    hit_row   = !row_s_q[0] ? 2'd0 : !row_s_q[1] ? 2'd1 : !row_s_q[2] ? 2'd2 : 2'd3;
    cand_open = row_s_q[cand_q[3:2]];
    deb_d     = deb_cnt_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      sync_q      <= 4'hF;
      row_s_q     <= 4'hF;
      pre_q       <= '0;
      col_idx_q   <= '0;
      deb_cnt_q   <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
`ifdef KEYPAD_RELEASE_EN
      key_release_q <= 1'b0;
`endif
    end else begin
      sync_q      <= kp.row_i;
      row_s_q     <= sync_q;
      pre_q       <= tick ? '0 : pre_q + 16'd1;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_RELEASE_EN
      key_release_q <= 1'b0;
`endif
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (!hit) col_idx_q <= col_idx_q + 2'd1;
            else if (DEBOUNCE_TICKS == 8'd1) begin
              cand_q      <= {hit_row, col_idx_q};
              key_code_q  <= {hit_row, col_idx_q};
              key_valid_q <= 1'b1;
              key_down_q  <= 1'b1;
              deb_cnt_q   <= '0;
              state_q     <= HELD;
            end else begin
              cand_q    <= {hit_row, col_idx_q};
              deb_cnt_q <= 8'd1;
              state_q   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (cand_open) begin
              deb_cnt_q <= '0;
              col_idx_q <= col_idx_q + 2'd1;
              state_q   <= SCAN;
            end else if (deb_d == DEBOUNCE_TICKS) begin
              key_code_q  <= cand_q;
              key_valid_q <= 1'b1;
              key_down_q  <= 1'b1;
              deb_cnt_q   <= '0;
              state_q     <= HELD;
            end else deb_cnt_q <= deb_d;
          end
          HELD: begin
            // any re-closure during release debounce restarts the count
            if (!cand_open) deb_cnt_q <= '0;
            else if (deb_d == DEBOUNCE_TICKS) begin
              key_down_q <= 1'b0;
`ifdef KEYPAD_RELEASE_EN
              key_release_q <= 1'b1;
`endif
              deb_cnt_q  <= '0;
              col_idx_q  <= col_idx_q + 2'd1;
              state_q    <= SCAN;
            end else deb_cnt_q <= deb_d;
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end
  assign kp.col_o       = ~(4'b0001 << col_idx_q);
  assign kp.key_code_o  = key_code_q;
  assign kp.key_valid_o = key_valid_q;
  assign kp.key_down_o  = key_down_q;
endmodule
